trng_harvester: RTL and testbench

- Downstream consumer of the ring-oscillator bank in the TRNG.
- Drives the oscillator enables and synchronises the asynchronous oscillator outputs into the clock domain.
- XOR-combines the synchronised outputs and samples the result at a programmable rate.
- Packs accepted bits into words and hands them to the peripheral register interface over a valid/ready handshake.

---
 rtl/trng_harvester.sv | 201 ++++++++++++++++++++
 tb/tb_trng_harvester.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_harvester.sv
// trng_harvester: drives the ring-oscillator enables, synchronises and XOR-combines the
// oscillator outputs, samples the result on a divided tick, packs accepted bits MSB-first
// into words and offers them on a valid/ready handshake.
// Optional build macro: TRNG_VON_NEUMANN_EN enables von Neumann debiasing of tick bits.
module trng_harvester #(
    parameter int unsigned NUM_RO        = 4,
    parameter int unsigned WORD_W        = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SAMPLE_DIV    = 4,
    parameter int unsigned WARMUP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_RO-1:0] ro_in,
    output logic              ro_en,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready
);

    localparam int unsigned WarmW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int unsigned DivW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CntW  = $clog2(WORD_W + 1);

    localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_CYCLES - 1);
    localparam logic [DivW-1:0]  DivLast  = DivW'(SAMPLE_DIV - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(WORD_W);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWarmup  = 2'd1;
    localparam logic [1:0] StCollect = 2'd2;
    localparam logic [1:0] StFull    = 2'd3;

    logic [SYNC_STAGES-1:0][NUM_RO-1:0] sync_q;
    logic                               raw_bit;

    logic [1:0]        state_q, state_d;
    logic [WarmW-1:0]  warm_q, warm_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ro_en_q;

    logic collecting;
    logic tick;
    logic accept;
    logic accept_bit;

    // Multi-flop synchroniser for every asynchronous oscillator output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
        end
    end

    assign raw_bit = ^sync_q[SYNC_STAGES-1];

    // Sampling only happens while a word is still being filled and enable holds.
    assign collecting = (state_q == StCollect) && enable && (cnt_q != CntFull);
    assign tick       = collecting && (div_q == DivLast);

`ifdef TRNG_VON_NEUMANN_EN
    logic pair_full_q, pair_full_d;
    logic pair_bit_q, pair_bit_d;
    logic pair_clr;

    // Pair state is dropped whenever sampling is not active, so every COLLECT entry
    // starts on a fresh pair.
    assign pair_clr = !collecting;

    // Pair up tick bits; a differing pair emits its first bit, 00 and 11 emit nothing.
    always_comb begin
        accept      = 1'b0;
        accept_bit  = pair_bit_q;
        pair_full_d = pair_full_q;
        pair_bit_d  = pair_bit_q;
        if (pair_clr) begin
            pair_full_d = 1'b0;
            pair_bit_d  = 1'b0;
        end else if (tick) begin
            if (!pair_full_q) begin
                pair_full_d = 1'b1;
                pair_bit_d  = raw_bit;
            end else begin
                pair_full_d = 1'b0;
                pair_bit_d  = 1'b0;
                accept      = (raw_bit != pair_bit_q);
            end
        end
    end

    // Pair state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_full_q <= 1'b0;
            pair_bit_q  <= 1'b0;
        end else begin
            pair_full_q <= pair_full_d;
            pair_bit_q  <= pair_bit_d;
        end
    end
`else
    assign accept     = tick;
    assign accept_bit = raw_bit;
`endif

    // Harvest FSM: warmup, divided sampling, word hand-off; enable=0 aborts from anywhere.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (!enable && (state_q != StIdle)) begin
            state_d = StIdle;
            warm_d  = '0;
            div_d   = '0;
            cnt_d   = '0;
            shift_d = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_d = StWarmup;
                        warm_d  = WarmLast;
                    end
                end
                StWarmup: begin
                    if (warm_q == '0) begin
                        state_d = StCollect;
                        div_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        warm_d = warm_q - 1'b1;
                    end
                end
                StCollect: begin
                    if (cnt_q == CntFull) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StFull;
                        cnt_d   = '0;
                    end else begin
                        div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
                        if (accept) begin
                            shift_d = {shift_q[WORD_W-2:0], accept_bit};
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end
                end
                StFull: begin
                    if (valid_q && rnd_ready) begin
                        valid_d = 1'b0;
                        state_d = StCollect;
                        div_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers; ro_en follows the next state so it tracks state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            warm_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ro_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ro_en_q <= (state_d != StIdle);
        end
    end

    assign ro_en     = ro_en_q;
    assign rnd_data  = data_q;
    assign rnd_valid = valid_q;

endmodule

// File: tb/tb_trng_harvester.sv
// Bench for trng_harvester: two instances (undivided single-RO, and divided 3-RO) share
// enable/ready/reset; a word-level reference model checks both every cycle, alongside a
// directed vector table and hand-written abort and divider sequences.
module tb_trng_harvester;

    typedef struct {
        bit       rs;
        bit       en;
        bit       rdy;
        bit       ro;
        bit       e_roen;
        bit       e_valid;
        bit [7:0] e_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       rnd_ready = 1'b0;
    logic [0:0] ro_a = 1'b0;
    logic [2:0] ro_b = 3'b000;

    logic       ro_en_a, valid_a, ro_en_b, valid_b;
    logic [7:0] data_a, data_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int       md [2] = '{1, 4};
    int       mw [2] = '{4, 5};
    int       ms [2] = '{2, 3};
    bit       m_on [2];
    int       coll_t [2];
    int       nacc [2];
    bit [7:0] acc [2];
    int       pair_n [2];
    bit       pair_b [2];
    bit [7:0] hist [2];
    bit       e_roen [2];
    bit       e_valid [2];
    bit [7:0] e_data [2];

    always #5 clk = ~clk;

    trng_harvester #(
        .NUM_RO(1), .WORD_W(8), .SYNC_STAGES(2), .SAMPLE_DIV(1), .WARMUP_CYCLES(4)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .ro_in(ro_a), .ro_en(ro_en_a),
        .rnd_data(data_a), .rnd_valid(valid_a), .rnd_ready(rnd_ready)
    );

    trng_harvester #(
        .NUM_RO(3), .WORD_W(8), .SYNC_STAGES(3), .SAMPLE_DIV(4), .WARMUP_CYCLES(5)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .ro_in(ro_b), .ro_en(ro_en_b),
        .rnd_data(data_b), .rnd_valid(valid_b), .rnd_ready(rnd_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // A tick bit reaches the conditioner; accepted bits append to the word being built.
    task automatic offer(input int id, input bit b);
`ifdef TRNG_VON_NEUMANN_EN
        if (pair_n[id] == 0) begin
            pair_b[id] = b;
            pair_n[id] = 1;
        end else begin
            pair_n[id] = 0;
            if (b != pair_b[id]) begin
                acc[id] = 8'((acc[id] * 2) + pair_b[id]);
                nacc[id]++;
            end
        end
`else
        acc[id] = 8'((acc[id] * 2) + b);
        nacc[id]++;
`endif
    endtask

    // Edge-level model: raw bit is the XOR of ro_in seen S edges ago; ticks fall every D
    // edges after collection (re)starts; a full word appears one edge after its last bit.
    task automatic model_step(input int id, input bit rs, input bit en, input bit rdy,
                              input bit x);
        bit raw;
        raw = hist[id][ms[id]-1];
        if (rs) hist[id] = 8'h00;
        else hist[id] = {hist[id][6:0], x};
        if (rs || (m_on[id] && !en)) begin
            m_on[id]    = 1'b0;
            e_roen[id]  = 1'b0;
            e_valid[id] = 1'b0;
            e_data[id]  = 8'h00;
        end else if (!m_on[id]) begin
            if (en) begin
                m_on[id]   = 1'b1;
                e_roen[id] = 1'b1;
                coll_t[id] = cyc + mw[id];
                nacc[id]   = 0;
                acc[id]    = 8'h00;
                pair_n[id] = 0;
            end
        end else if (e_valid[id]) begin
            if (rdy) begin
                e_valid[id] = 1'b0;
                coll_t[id]  = cyc;
            end
        end else if (cyc > coll_t[id]) begin
            if (nacc[id] == 8) begin
                e_valid[id] = 1'b1;
                e_data[id]  = acc[id];
                nacc[id]    = 0;
                pair_n[id]  = 0;
            end else if (((cyc - coll_t[id]) % md[id]) == 0) begin
                offer(id, raw);
            end
        end
    endtask

    // Model runs on every edge for both instances and compares all outputs.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0, rst, enable, rnd_ready, ^ro_a);
            model_step(1, rst, enable, rnd_ready, ^ro_b);
            #1;
            check("model_a_ro_en", 32'(ro_en_a), 32'(e_roen[0]));
            check("model_a_valid", 32'(valid_a), 32'(e_valid[0]));
            check("model_a_data", 32'(data_a), 32'(e_data[0]));
            check("model_b_ro_en", 32'(ro_en_b), 32'(e_roen[1]));
            check("model_b_valid", 32'(valid_b), 32'(e_valid[1]));
            check("model_b_data", 32'(data_b), 32'(e_data[1]));
        end
    end

    task automatic step(input bit r, input bit e, input bit rd, input bit a,
                        input logic [2:0] b);
        @(negedge clk);
        rst       = r;
        enable    = e;
        rnd_ready = rd;
        ro_a      = a;
        ro_b      = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t     vec [$];
        vec_t     v;
        bit       tb_bits [$];
        bit       pat [$];
        bit [7:0] word;
        bit [7:0] pword;
        bit [19:0] pairs;
        int       n;
        int       t;
        int       tdiv;
        bit       en_r;

`ifdef TRNG_VON_NEUMANN_EN
        pairs = 20'b01_11_10_00_10_01_01_10_10_10;
        for (int i = 19; i >= 0; i--) tb_bits.push_back(pairs[i]);
        word = 8'h67;
        tdiv = 16;
`else
        pword = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) tb_bits.push_back(pword[i]);
        word = 8'hB2;
        tdiv = 8;
`endif
        pword = 8'hC5;
        for (int i = 7; i >= 0; i--) begin
            pat.push_back(pword[i]);
`ifdef TRNG_VON_NEUMANN_EN
            pat.push_back(!pword[i]);
`endif
        end

        // Vector table for dut_a: reset, warmup, first word, 20-cycle backpressure, handshake.
        n = tb_bits.size();
        for (int r = 0; r <= 29 + n; r++) begin
            v.rs  = (r < 2);
            v.en  = (r != 2);
            v.ro  = (r < 2) ? bit'(r % 2) : 1'b0;
            if (r >= 6 && r - 6 < n) v.ro = tb_bits[r-6];
            v.rdy = (r >= 3 && r <= 8 + n) || (r == 29 + n);
            v.e_roen  = (r >= 3);
            v.e_valid = (r >= 8 + n) && (r <= 28 + n);
            v.e_data  = (r >= 8 + n) ? word : 8'h00;
            vec.push_back(v);
        end
        foreach (vec[i]) begin
            step(vec[i].rs, vec[i].en, vec[i].rdy, vec[i].ro, 3'b000);
            check($sformatf("vec%0d_ro_en", i), 32'(ro_en_a), 32'(vec[i].e_roen));
            check($sformatf("vec%0d_valid", i), 32'(valid_a), 32'(vec[i].e_valid));
            check($sformatf("vec%0d_data", i), 32'(data_a), 32'(vec[i].e_data));
        end

        // Abort mid-word, then re-enable: full warmup and a fresh word with no stale bits.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
        check("abort_ro_en", 32'(ro_en_a), 32'd0);
        check("abort_valid", 32'(valid_a), 32'd0);
        check("abort_data", 32'(data_a), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
            check("idle_ro_en", 32'(ro_en_a), 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        check("reenable_ro_en", 32'(ro_en_a), 32'd1);
        t = pat.size();
        for (int j = 1; j <= 5 + t; j++) begin
            step(1'b0, 1'b1, 1'b0, (j >= 3 && j - 3 < t) ? pat[j-3] : 1'b0, 3'b000);
            if (j < 5 + t) begin
                check("reenable_no_early_valid", 32'(valid_a), 32'd0);
            end else begin
                check("reenable_valid", 32'(valid_a), 32'd1);
                check("reenable_data", 32'(data_a), 32'hC5);
            end
        end

        // Divider on dut_b: one tick every 4 cycles, word of ones one edge after last tick.
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int j = 0; j <= 5 + 4 * tdiv + 1; j++) begin
            logic [2:0] b;
            int         u;
            u = j - 5 + 3;
`ifdef TRNG_VON_NEUMANN_EN
            b = (u >= 0 && ((u / 4) % 2) == 1) ? 3'b100 : 3'b110;
`else
            b = 3'b001;
`endif
            step(1'b0, 1'b1, 1'b0, 1'b0, b);
            if (j == 0) check("div_ro_en", 32'(ro_en_b), 32'd1);
            if (j < 5 + 4 * tdiv + 1) begin
                check("div_no_early_valid", 32'(valid_b), 32'd0);
            end else begin
                check("div_valid", 32'(valid_b), 32'd1);
                check("div_data", 32'(data_b), 32'hFF);
            end
        end

        // Randomised traffic: model checks every cycle.
        en_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) == 0) en_r = !en_r;
            else if (!en_r && $urandom_range(7) == 0) en_r = 1'b1;
            step(($urandom_range(299) == 0), en_r, ($urandom_range(2) == 0),
                 1'($urandom_range(1)), 3'($urandom_range(7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
